// File: rtl/ram_axi_slave.sv
// ram_axi_slave: AXI4 responder over a single-clock 32-bit word RAM.
// Read and write channels run independent FSMs over the shared array, so bursts may overlap.
module ram_axi_slave #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWID,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARID,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic        S_AXI_RID,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);
  localparam int AW = DEPTH_LOG2;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] mem [2**AW];
  logic [AW-1:0] w_idx, r_idx, r_nidx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_fixed, r_fixed, w_err;
  logic aw_hs, w_hs, w_last, b_hs, ar_hs, r_hs, r_end;
  logic unused;
  assign unused = ^{S_AXI_AWADDR[31:AW+2], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:AW+2], S_AXI_ARADDR[1:0]};
  assign aw_hs = S_AXI_AWVALID && w_state == W_IDLE;
  assign w_hs = S_AXI_WVALID && w_state == W_DATA;
  assign w_last = w_cnt == w_len;
  assign b_hs = S_AXI_BREADY && w_state == W_RESP;
  assign ar_hs = S_AXI_ARVALID && r_state == R_IDLE;
  assign r_hs = S_AXI_RREADY && r_state == R_DATA;
  assign r_end = r_cnt == r_len;
  assign r_nidx = r_fixed ? r_idx : r_idx + AW'(1);
  assign S_AXI_AWREADY = w_state == W_IDLE;
  assign S_AXI_WREADY = w_state == W_DATA;
  assign S_AXI_BVALID = w_state == W_RESP;
  assign S_AXI_ARREADY = r_state == R_IDLE;
  assign S_AXI_RVALID = r_state == R_DATA;
  assign S_AXI_RLAST = S_AXI_RVALID && r_end;
  always_comb begin
    w_next = aw_hs ? W_DATA : (w_hs && w_last) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_next = ar_hs ? R_DATA : (r_hs && r_end) ? R_IDLE : r_state;
  end
  // Beat count, not WLAST, closes the burst; a misplaced WLAST only sets SLVERR.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      w_state <= W_IDLE;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_fixed <= 1'b0;
      w_err <= 1'b0;
      S_AXI_BID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_idx <= S_AXI_AWADDR[AW+1:2];
        w_len <= S_AXI_AWLEN;
        w_cnt <= '0;
        w_fixed <= S_AXI_AWBURST == 2'b00;
        w_err <= S_AXI_AWSIZE != 3'b010;
        S_AXI_BID <= S_AXI_AWID;
      end
      if (w_hs) begin
        w_idx <= w_fixed ? w_idx : w_idx + AW'(1);
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err || (S_AXI_WLAST != w_last);
        if (w_last) S_AXI_BRESP <= (w_err || !S_AXI_WLAST) ? 2'b10 : 2'b00;
      end
    end
  always_ff @(posedge CLK)
    for (int i = 0; i < 4; i++)
      if (w_hs && S_AXI_WSTRB[i]) mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
  // Loads sample mem before a same-edge write lands, giving read-before-write.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= R_IDLE;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_fixed <= 1'b0;
      S_AXI_RID <= 1'b0;
      S_AXI_RRESP <= 2'b00;
      S_AXI_RDATA <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_idx <= S_AXI_ARADDR[AW+1:2];
        r_len <= S_AXI_ARLEN;
        r_cnt <= '0;
        r_fixed <= S_AXI_ARBURST == 2'b00;
        S_AXI_RID <= S_AXI_ARID;
        S_AXI_RRESP <= S_AXI_ARSIZE == 3'b010 ? 2'b00 : 2'b10;
        S_AXI_RDATA <= mem[S_AXI_ARADDR[AW+1:2]];
      end
      if (r_hs && !r_end) begin
        r_idx <= r_nidx;
        r_cnt <= r_cnt + 8'd1;
        S_AXI_RDATA <= mem[r_nidx];
      end
    end
endmodule

// File: tb/tb_ram_axi_slave.sv
// tb_ram_axi_slave: randomized AXI traffic against a word-array model of the RAM,
// with a per-cycle R/B channel checker and literal expectations from the test plan.
module tb_ram_axi_slave;
  localparam int DL = 12;
  localparam int DEPTH = 1 << DL;
  logic clk = 0, rst = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  logic [3:0] wstrb = 0;
  logic awid = 0, awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
  logic bid, bvalid, bready = 0, arid = 0, arvalid = 0, arready;
  logic rid, rlast, rvalid, rready = 0;

  always #5 clk = ~clk;

  ram_axi_slave #(.DEPTH_LOG2(DL)) dut (
    .CLK(clk), .RST(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWID(awid), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARID(arid), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct { logic [31:0] data; logic last; logic [1:0] resp; logic id; } rbeat_t;
  typedef struct { logic [1:0] resp; logic id; } bexp_t;
  int n_chk = 0, n_fail = 0;
  logic [31:0] model [DEPTH];
  rbeat_t rq [$];
  bexp_t bq [$];
  logic [31:0] wd [256];
  logic [3:0] ws [256];
  logic [31:0] cap [256];
  logic [1:0] cap_resp, last_bresp;
  logic last_bid;
  logic [7:0] pat = 8'b1111_1001;
  logic r_hold = 0, b_hold = 0;
  logic [31:0] h_rdata;
  logic [3:0] h_rctl;
  logic [2:0] h_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int beat, input logic [1:0] burst);
    return int'(((addr >> 2) + (burst == 2'b00 ? 0 : beat)) % DEPTH);
  endfunction

  task automatic check_r();
    rbeat_t e;
    if (rq.size() == 0) chk("r_unexpected_beat", rq.size(), 1);
    else begin
      e = rq.pop_front();
      chk("r_data", rdata, e.data);
      chk("r_last", rlast, e.last);
      chk("r_id_resp", {rid, rresp}, {e.id, e.resp});
    end
  endtask

  task automatic check_b();
    bexp_t e;
    if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
    else begin
      e = bq.pop_front();
      chk("b_id_resp", {bid, bresp}, {e.id, e.resp});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      bq.delete();
      r_hold <= 0;
      b_hold <= 0;
    end else begin
      if (r_hold) begin
        chk("r_hold_data", rdata, h_rdata);
        chk("r_hold_ctl", {rlast, rid, rresp}, h_rctl);
      end
      if (b_hold) chk("b_hold", {bid, bresp}, h_b);
      if (rvalid && rready) check_r();
      if (bvalid && bready) check_b();
      r_hold <= rvalid && !rready;
      h_rdata <= rdata;
      h_rctl <= {rlast, rid, rresp};
      b_hold <= bvalid && !bready;
      h_b <= {bid, bresp};
    end
  end

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id, input int last_at, input bit gaps);
    int t;
    bexp_t e;
    @(posedge clk); #1;
    e.resp = (size != 3'b010 || last_at != len) ? 2'b10 : 2'b00;
    e.id = id;
    bq.push_back(e);
    awaddr = addr; awlen = len[7:0]; awburst = burst; awsize = size; awid = id; awvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    chk("aw_accept", awready, 1);
    @(posedge clk); #1 awvalid = 0;
    @(negedge clk);
    chk("wready_after_aw", {wready, awready}, 2'b10);
    @(posedge clk); #1;
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at); wvalid = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 100);
      chk("w_accept", wready, 1);
      for (int i = 0; i < 4; i++)
        if (ws[b][i]) model[widx(addr, b, burst)][8*i +: 8] = wd[b][8*i +: 8];
      @(posedge clk); #1 wvalid = 0; wlast = 0;
    end
    @(negedge clk);
    chk("bvalid_after_w", {bvalid, wready}, 2'b10);
    @(posedge clk); #1;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    bready = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 100);
    chk("b_valid", bvalid, 1);
    last_bresp = bresp;
    last_bid = bid;
    @(posedge clk); #1 bready = 0;
    @(negedge clk);
    chk("awready_after_b", {awready, bvalid}, 2'b10);
  endtask

  task automatic push_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id);
    rbeat_t e;
    for (int b = 0; b <= len; b++) begin
      e.data = model[widx(addr, b, burst)];
      e.last = (b == len);
      e.resp = size == 3'b010 ? 2'b00 : 2'b10;
      e.id = id;
      rq.push_back(e);
    end
    araddr = addr; arlen = len[7:0]; arburst = burst; arsize = size; arid = id; arvalid = 1;
  endtask

  // bp: 0 = RREADY held high, 1 = fixed pattern, 2 = random
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic id, input int bp);
    int t, got;
    @(posedge clk); #1;
    push_read(addr, len, burst, size, id);
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    chk("ar_accept", arready, 1);
    @(posedge clk); #1 arvalid = 0;
    got = 0;
    t = 0;
    while (got <= len && t < 4000) begin
      rready = bp == 0 ? 1'b1 : bp == 1 ? pat[t % 8] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (t == 0) chk("rvalid_after_ar", rvalid, 1);
      if (rvalid && rready) begin
        cap[got] = rdata;
        cap_resp = rresp;
        got++;
      end
      t++;
      @(posedge clk); #1;
    end
    rready = 0;
    chk("r_beats", got, len + 1);
    if (bp == 0) chk("r_b2b_cycles", t, len + 1);
    @(negedge clk);
    chk("arready_after_r", {arready, rvalid}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wa, ra;
    int wl, rl, wla;
    logic [1:0] wbst, rbst;
    logic [2:0] wsz, rsz;
    logic wi, ri;
    @(negedge clk);
    chk("reset_ready", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b110000);
    chk("reset_ids", {bid, bresp, rid, rresp}, 0);
    chk("reset_rdata", rdata, 0);
    @(posedge clk); #1 rst = 0;

    for (int b = 0; b < 128; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    axi_write(32'h0, 127, 2'b01, 3'b010, 1'b0, 127, 0);

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(32'h100, 0, 2'b01, 3'b010, 1'b1, 0, 0);
    chk("single_bid_bresp", {last_bid, last_bresp}, 3'b100);
    axi_read(32'h100, 0, 2'b01, 3'b010, 1'b1, 0);
    chk("single_rdata", cap[0], 32'hDEADBEEF);
    chk("single_rresp", cap_resp, 2'b00);

    for (int b = 0; b < 32; b++) begin wd[b] = b; ws[b] = 4'hF; end
    axi_write(32'h1000, 31, 2'b01, 3'b010, 1'b0, 31, 0);
    axi_read(32'h1000, 31, 2'b01, 3'b010, 1'b0, 0);
    chk("burst_beat0", cap[0], 0);
    chk("burst_beat31", cap[31], 31);

    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(32'h20, 0, 2'b01, 3'b010, 1'b0, 0, 0);
    wd[0] = 32'h12345678; ws[0] = 4'h5;
    axi_write(32'h20, 0, 2'b01, 3'b010, 1'b0, 0, 0);
    axi_read(32'h20, 0, 2'b01, 3'b010, 1'b0, 0);
    chk("strobe_merge", cap[0], 32'hFF34FF78);
    axi_read(32'h20 + 4 * DEPTH, 0, 2'b01, 3'b010, 1'b0, 0);
    chk("alias_read", cap[0], 32'hFF34FF78);

    for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0000000 + b; ws[b] = 4'hF; end
    axi_write(4 * (DEPTH - 1), 3, 2'b01, 3'b010, 1'b0, 3, 0);
    axi_read(4 * (DEPTH - 1), 3, 2'b01, 3'b010, 1'b1, 1);
    chk("wrap_top", cap[0], 32'hA0000000);
    chk("wrap_word0", cap[1], 32'hA0000001);
    chk("wrap_word2", cap[3], 32'hA0000003);

    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    axi_write(32'h200, 3, 2'b01, 3'b010, 1'b1, 1, 0);
    chk("early_wlast_bresp", last_bresp, 2'b10);
    axi_read(32'h200, 3, 2'b01, 3'b001, 1'b0, 2);
    chk("size_err_rresp", cap_resp, 2'b10);
    axi_write(32'h200, 0, 2'b01, 3'b000, 1'b0, 0, 0);
    chk("size_err_bresp", last_bresp, 2'b10);

    for (int b = 0; b < 4; b++) begin wd[b] = 32'hC0000000 + b; ws[b] = 4'hF; end
    axi_write(32'h300, 3, 2'b00, 3'b010, 1'b0, 3, 0);
    axi_read(32'h300, 2, 2'b00, 3'b010, 1'b0, 2);
    chk("fixed_last_wins", cap[2], 32'hC0000003);

    for (int it = 0; it < 40; it++) begin
      wl = $urandom_range(0, 15);
      rl = $urandom_range(0, 15);
      wa = ($urandom_range(0, 47) << 2) | ($urandom & 3) | ($urandom_range(0, 3) << (DL + 2));
      ra = ($urandom_range(64, 110) << 2) | ($urandom & 3) | ($urandom_range(0, 3) << (DL + 2));
      wbst = 2'($urandom_range(0, 2));
      rbst = 2'($urandom_range(0, 2));
      wsz = $urandom_range(0, 4) == 0 ? 3'b001 : 3'b010;
      rsz = $urandom_range(0, 4) == 0 ? 3'b000 : 3'b010;
      wla = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, wl)) : wl;
      wi = 1'($urandom);
      ri = 1'($urandom);
      for (int b = 0; b <= wl; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
      fork
        axi_write(wa, wl, wbst, wsz, wi, wla, 1);
        axi_read(ra, rl, rbst, rsz, ri, 2);
      join
      axi_read(wa, wl, wbst, 3'b010, wi, 2);
    end

    for (int b = 0; b < 32; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    axi_write(32'h2000, 31, 2'b01, 3'b010, 1'b0, 31, 0);
    @(posedge clk); #1;
    push_read(32'h2000, 31, 2'b01, 3'b010, 1'b0);
    @(negedge clk);
    chk("rst_ar_accept", arready, 1);
    @(posedge clk); #1 arvalid = 0; rready = 1;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_beat5_valid", rvalid, 1);
    rst = 1;
    #1;
    chk("rst_mid_ready", {rvalid, arready, rlast, awready}, 4'b0101);
    chk("rst_mid_rdata", rdata, 0);
    rready = 0;
    @(posedge clk); #1 rst = 0;
    axi_read(32'h2000, 31, 2'b01, 3'b010, 1'b0, 0);

    repeat (3) @(posedge clk);
    chk("queues_drained", rq.size() + bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
